// File: rtl/mem_dep_predictor_sat.sv
// mem_dep_predictor_sat
//   PC-indexed table of COUNTER_WIDTH-bit saturating counters that predicts
//   whether a load must wait for older stores. It has multiple lookup and
//   update ports and a built-in sequential clear engine. The clear engine
//   runs after reset, on clearReq, and every CLEAR_INTERVAL active cycles.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   lookupValid/PC   per-port lookup request (dispatch)
//   predictDepend    per-port prediction, registered (valid one cycle later)
//   updateValid/PC   per-port training request (load-store unit)
//   updateViolation  1 = ordering violation (saturate high), 0 = safe (decrement)
//   clearReq         force a sweep (ignored while already sweeping)
//   busy             sweep in progress
//
// Optional feature macro: MEM_DEP_PREDICTOR_STAT_EN
//   adds statViolationCount / statPredictCount (32-bit, wrap, cleared by rst only)
module mem_dep_predictor_sat #(
  parameter int unsigned ENTRY_NUM           = 1024,
  parameter int unsigned COUNTER_WIDTH       = 2,
  parameter int unsigned THRESHOLD           = 2,
  parameter int unsigned READ_PORT_NUM       = 2,
  parameter int unsigned WRITE_PORT_NUM      = 2,
  parameter int unsigned CLEAR_WIDTH         = 4,
  parameter int unsigned CLEAR_INTERVAL      = 65536,
  parameter int unsigned PC_WIDTH            = 32,
  parameter int unsigned INSN_ADDR_BIT_WIDTH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [READ_PORT_NUM-1:0]                 lookupValid,
  input  logic [READ_PORT_NUM-1:0][PC_WIDTH-1:0]   lookupPC,
  output logic [READ_PORT_NUM-1:0]                 predictDepend,
  input  logic [WRITE_PORT_NUM-1:0]                updateValid,
  input  logic [WRITE_PORT_NUM-1:0][PC_WIDTH-1:0]  updatePC,
  input  logic [WRITE_PORT_NUM-1:0]                updateViolation,
  input  logic                                     clearReq,
  output logic                                     busy
`ifdef MEM_DEP_PREDICTOR_STAT_EN
  ,
  output logic [31:0]                              statViolationCount,
  output logic [31:0]                              statPredictCount
`endif
);

  localparam int unsigned IDXW = $clog2(ENTRY_NUM);
  localparam int unsigned IW   = (CLEAR_INTERVAL > 1) ? $clog2(CLEAR_INTERVAL) : 1;
  localparam logic [IW-1:0] INTERVAL_LAST =
    (CLEAR_INTERVAL > 0) ? IW'(CLEAR_INTERVAL - 1) : '0;
  localparam logic [IDXW-1:0] PTR_LAST = IDXW'(ENTRY_NUM - CLEAR_WIDTH);
  localparam logic [IDXW-1:0] PTR_STEP = IDXW'(CLEAR_WIDTH);
  localparam logic [COUNTER_WIDTH-1:0] THR = COUNTER_WIDTH'(THRESHOLD);

  typedef enum logic {
    CLEAR,
    ACTIVE
  } stateT;

  stateT                    state;
  logic [IDXW-1:0]          sweepPtr;
  logic [IW-1:0]            intervalCnt;
  logic [COUNTER_WIDTH-1:0] cntTable [ENTRY_NUM];

  logic [READ_PORT_NUM-1:0] predictNext;
  logic                     periodicHit;
  logic [IDXW-1:0]          wrIdx [WRITE_PORT_NUM];
  logic [COUNTER_WIDTH-1:0] wrCur [WRITE_PORT_NUM];
  logic [COUNTER_WIDTH-1:0] wrVal [WRITE_PORT_NUM];
  logic [WRITE_PORT_NUM-1:0] wrHasViol;

  // Only the index bits of each PC are used.
  logic unusedPcBits;
  assign unusedPcBits = ^{lookupPC, updatePC};

  function automatic logic [IDXW-1:0] pcIndex(input logic [PC_WIDTH-1:0] pc);
    return pc[INSN_ADDR_BIT_WIDTH +: IDXW];
  endfunction

  assign periodicHit = (CLEAR_INTERVAL != 0) && (intervalCnt == INTERVAL_LAST);

  // Lookups read the table before this cycle's updates land (read-first).
  always_comb begin
    predictNext = '0;
    for (int unsigned r = 0; r < READ_PORT_NUM; r++) begin
      predictNext[r] = (state == ACTIVE) && lookupValid[r] &&
                       (cntTable[pcIndex(lookupPC[r])] >= THR);
    end
  end

  always_comb begin
    for (int unsigned w = 0; w < WRITE_PORT_NUM; w++) begin
      wrIdx[w] = pcIndex(updatePC[w]);
    end
  end

  // Every port hitting the same index computes the same merged value, so
  // colliding writes are harmless: any violation saturates, otherwise a
  // single decrement from the old value.
  always_comb begin
    wrHasViol = '0;
    for (int unsigned w = 0; w < WRITE_PORT_NUM; w++) begin
      for (int unsigned v = 0; v < WRITE_PORT_NUM; v++) begin
        if (updateValid[v] && updateViolation[v] && (wrIdx[v] == wrIdx[w])) begin
          wrHasViol[w] = 1'b1;
        end
      end
      wrCur[w] = cntTable[wrIdx[w]];
      if (wrHasViol[w]) begin
        wrVal[w] = '1;
      end else if (wrCur[w] == '0) begin
        wrVal[w] = '0;
      end else begin
        wrVal[w] = wrCur[w] - COUNTER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CLEAR;
      sweepPtr      <= '0;
      intervalCnt   <= '0;
      busy          <= 1'b1;
      predictDepend <= '0;
    end else begin
      predictDepend <= predictNext;
      case (state)
        CLEAR: begin
          sweepPtr <= sweepPtr + PTR_STEP;
          if (sweepPtr == PTR_LAST) begin
            state <= ACTIVE;
            busy  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (periodicHit || clearReq) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            sweepPtr    <= '0;
            intervalCnt <= '0;
          end else begin
            intervalCnt <= intervalCnt + IW'(1);
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        for (int unsigned c = 0; c < CLEAR_WIDTH; c++) begin
          cntTable[sweepPtr + IDXW'(c)] <= '0;
        end
      end else begin
        for (int unsigned w = 0; w < WRITE_PORT_NUM; w++) begin
          if (updateValid[w]) begin
            cntTable[wrIdx[w]] <= wrVal[w];
          end
        end
      end
    end
  end

`ifdef MEM_DEP_PREDICTOR_STAT_EN
  logic [31:0] violEvents;
  logic [31:0] predEvents;

  always_comb begin
    violEvents = '0;
    predEvents = '0;
    for (int unsigned w = 0; w < WRITE_PORT_NUM; w++) begin
      if ((state == ACTIVE) && updateValid[w] && updateViolation[w]) begin
        violEvents = violEvents + 32'd1;
      end
    end
    for (int unsigned r = 0; r < READ_PORT_NUM; r++) begin
      if (predictNext[r]) begin
        predEvents = predEvents + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      statViolationCount <= '0;
      statPredictCount   <= '0;
    end else begin
      statViolationCount <= statViolationCount + violEvents;
      statPredictCount   <= statPredictCount + predEvents;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dep_predictor_sat.sv
// Directed bench for mem_dep_predictor_sat. Two instances share stimulus:
// dut uses default parameters, dutI uses CLEAR_INTERVAL=16 with its own reset.
// PCs 0x1000, 0x2000, 0x3000 all map to table index 0; 0x1004 maps to index 1.
module tb_mem_dep_predictor_sat;

  logic             clk = 1'b0;
  logic             rst;
  logic             iRst;
  logic [1:0]       lookupValid;
  logic [1:0][31:0] lookupPC;
  logic [1:0]       updateValid;
  logic [1:0][31:0] updatePC;
  logic [1:0]       updateViolation;
  logic             clearReq;
  logic [1:0]       pd;
  logic             busy;
  logic [1:0]       iPd;
  logic             iBusy;

  int checks   = 0;
  int failures = 0;
  int busyCycles;
  int activeTicks;

`ifdef MEM_DEP_PREDICTOR_STAT_EN
  logic [31:0] sv0, sp0, sv1, sp1;
`endif

  always #5 clk = ~clk;

  mem_dep_predictor_sat dut (
    .clk(clk), .rst(rst),
    .lookupValid(lookupValid), .lookupPC(lookupPC), .predictDepend(pd),
    .updateValid(updateValid), .updatePC(updatePC),
    .updateViolation(updateViolation), .clearReq(clearReq), .busy(busy)
`ifdef MEM_DEP_PREDICTOR_STAT_EN
    , .statViolationCount(sv0), .statPredictCount(sp0)
`endif
  );

  mem_dep_predictor_sat #(.CLEAR_INTERVAL(16)) dutI (
    .clk(clk), .rst(iRst),
    .lookupValid(lookupValid), .lookupPC(lookupPC), .predictDepend(iPd),
    .updateValid(updateValid), .updatePC(updatePC),
    .updateViolation(updateViolation), .clearReq(clearReq), .busy(iBusy)
`ifdef MEM_DEP_PREDICTOR_STAT_EN
    , .statViolationCount(sv1), .statPredictCount(sp1)
`endif
  );

  task automatic idle();
    lookupValid     = '0;
    updateValid     = '0;
    updateViolation = '0;
    clearReq        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic look(input int p, input logic [31:0] pc);
    lookupValid[p] = 1'b1;
    lookupPC[p]    = pc;
  endtask

  task automatic upd(input int p, input logic [31:0] pc, input logic viol);
    updateValid[p]     = 1'b1;
    updatePC[p]        = pc;
    updateViolation[p] = viol;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    lookupPC = '0;
    updatePC = '0;
    rst  = 1'b1;
    iRst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 1);
    chk("rst_pred", pd, 0);

    // Initial sweep: lookup returns 0, update and clearReq are ignored.
    busyCycles = 0;
    while (busy && busyCycles < 300) begin
      busyCycles++;
      if (busyCycles == 10) look(0, 32'h1000);
      if (busyCycles == 200) begin
        upd(0, 32'h1004, 1'b1);
        clearReq = 1'b1;
      end
      step();
      if (busyCycles == 10) chk("sweep_lookup", pd[0], 0);
    end
    chk("sweep_len", busyCycles, 256);
    step();
    chk("clrreq_ignored_in_clear", busy, 0);

    // Violation sets index 0 to 3; index 1 stays 0 (sweep-time update dropped).
    upd(0, 32'h1000, 1'b1); step();
    look(0, 32'h1000); look(1, 32'h1004); step();
    chk("viol_hit", pd[0], 1);
    chk("other_idx", pd[1], 0);
    step();
    chk("no_valid", pd, 0);

    // Decrement chain 3->2->1->0->0.
    upd(0, 32'h1000, 1'b0); step();
    upd(0, 32'h1000, 1'b0); look(0, 32'h1000); step();
    chk("dec_3to2", pd[0], 1);
    upd(0, 32'h1000, 1'b0); look(0, 32'h1000); step();
    chk("dec_2to1", pd[0], 0);
    upd(0, 32'h1000, 1'b0); look(0, 32'h1000); step();
    chk("dec_to0", pd[0], 0);
    look(0, 32'h1000); step();
    chk("sat_low", pd[0], 0);

    // Bring index 0 to 1, then same-cycle collisions.
    upd(0, 32'h2000, 1'b1); step();
    upd(0, 32'h2000, 1'b0); step();
    upd(0, 32'h2000, 1'b0); step();
    upd(0, 32'h2000, 1'b1); upd(1, 32'h2000, 1'b0); step();
    look(0, 32'h2000); step();
    chk("mixed_viol_wins", pd[0], 1);
    upd(0, 32'h2000, 1'b0); upd(1, 32'h2000, 1'b0); step();
    look(0, 32'h2000); upd(0, 32'h2000, 1'b0); step();
    chk("single_dec", pd[0], 1);
    look(0, 32'h2000); step();
    chk("single_dec_then", pd[0], 0);
    upd(0, 32'h2000, 1'b0); upd(1, 32'h2000, 1'b1); step();
    upd(0, 32'h2000, 1'b0); step();
    look(0, 32'h2000); step();
    chk("mixed_rev", pd[0], 1);
    upd(0, 32'h2000, 1'b0); step();
    upd(0, 32'h2000, 1'b0); step();

    // Read-first on same-cycle lookup and violation.
    look(0, 32'h3000); upd(1, 32'h3000, 1'b1); step();
    chk("rdfirst_old", pd[0], 0);
    look(0, 32'h3000); look(1, 32'h3000); step();
    chk("rdfirst_new", pd, 2'b11);

    // clearReq in ACTIVE starts a full sweep.
    clearReq = 1'b1; look(0, 32'h1000); step();
    chk("clrreq_busy", busy, 1);
    chk("clrreq_last_lookup", pd[0], 1);
    busyCycles = 0;
    while (busy && busyCycles < 300) begin
      busyCycles++;
      step();
    end
    chk("clrreq_len", busyCycles, 256);
    look(0, 32'h1000); step();
    chk("after_clrreq", pd[0], 0);

    // Periodic decay on the CLEAR_INTERVAL=16 instance.
    step();
    iRst = 1'b0;
    chk("i_rst_busy", iBusy, 1);
    busyCycles = 0;
    while (iBusy && busyCycles < 300) begin
      busyCycles++;
      step();
    end
    chk("i_sweep_len", busyCycles, 256);
    upd(0, 32'h1000, 1'b1); step();
    look(0, 32'h1000); step();
    chk("i_viol_hit", iPd[0], 1);
    activeTicks = 2;
    while (!iBusy && activeTicks < 40) begin
      activeTicks++;
      step();
    end
    chk("i_interval", activeTicks, 16);
    for (int k = 1; k < 100; k++) step();
    iRst = 1'b1; step();
    iRst = 1'b0;
    chk("i_rst_mid_busy", iBusy, 1);
    busyCycles = 0;
    while (iBusy && busyCycles < 300) begin
      busyCycles++;
      step();
    end
    chk("i_restart_len", busyCycles, 256);
    look(0, 32'h1000); step();
    chk("i_after_sweep", iPd[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
